// File: rtl/imm_table_ctrl.sv
// imm_table_ctrl: 8 x 8-bit immediate table with a three-way round-robin port.
// Requesters A (core decode, read), B (debug, read) and W (write) share one
// access slot per cycle. An INIT sweep loads default contents after reset or
// a reload pulse; grants are only issued while the table is in RUN.
module imm_table_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [2:0] a_idx,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic [2:0] b_idx,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  input  logic       w_req,
  input  logic [2:0] w_idx,
  input  logic [7:0] w_data,
  output logic       w_gnt,
  input  logic       reload,
  output logic       ready
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Arbiter pointer values: index of the requester searched first.
  localparam logic [1:0] PTR_A = 2'd0;
  localparam logic [1:0] PTR_B = 2'd1;
  localparam logic [1:0] PTR_W = 2'd2;

  // Default table contents, restored by every INIT sweep.
  function automatic logic [7:0] default_entry(input logic [2:0] idx);
    case (idx)
      3'd1:    default_entry = 8'd1;
      3'd2:    default_entry = 8'd29;
      3'd3:    default_entry = 8'd128;
      3'd4:    default_entry = 8'd59;
      3'd5:    default_entry = 8'd4;
      default: default_entry = 8'd0;
    endcase
  endfunction

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_ptr;
  logic [7:0] r_tbl [8];
  logic       r_a_rvalid;
  logic [7:0] r_a_rdata;
  logic       r_b_rvalid;
  logic [7:0] r_b_rdata;

  logic       w_arb_en;
  logic [2:0] w_gnt_vec;   // {W, B, A}

  // Grants are suppressed in INIT, in the reload cycle and while reset is high.
  assign w_arb_en = (r_state == ST_RUN) && !reload && !reset;

  // Round-robin pick: search A -> B -> W starting at the pointer.
  always_comb begin
    // NOTE: the grant vector is defaulted first so that no path leaves it unassigned and infers a latch.
    w_gnt_vec = 3'b000;
    if (w_arb_en) begin
      case (r_ptr)
        PTR_B: begin
          if      (b_req) w_gnt_vec = 3'b010;
          else if (w_req) w_gnt_vec = 3'b100;
          else if (a_req) w_gnt_vec = 3'b001;
        end
        PTR_W: begin
          if      (w_req) w_gnt_vec = 3'b100;
          else if (a_req) w_gnt_vec = 3'b001;
          else if (b_req) w_gnt_vec = 3'b010;
        end
        default: begin
          if      (a_req) w_gnt_vec = 3'b001;
          else if (b_req) w_gnt_vec = 3'b010;
          else if (w_req) w_gnt_vec = 3'b100;
        end
      endcase
    end
  end

  // Control FSM: INIT sweep counter, RUN/INIT transitions and arbiter pointer.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= 3'd0;
      r_ptr   <= PTR_A;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_ptr <= PTR_A;
          if (reload) begin
            r_cnt <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (reload) begin
            r_state <= ST_INIT;
            r_cnt   <= 3'd0;
            r_ptr   <= PTR_A;
          end else if (w_gnt_vec[0]) begin
            r_ptr <= PTR_B;
          end else if (w_gnt_vec[1]) begin
            r_ptr <= PTR_W;
          end else if (w_gnt_vec[2]) begin
            r_ptr <= PTR_A;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Table storage: INIT sweep writes defaults, RUN accepts granted writes.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; its contents are only defined once the INIT sweep has rewritten every entry.
    if (r_state == ST_INIT && !reload) begin
      r_tbl[r_cnt] <= default_entry(r_cnt);
    end else if (w_gnt_vec[2]) begin
      r_tbl[w_idx] <= w_data;
    end
  end

  // Read responses: one-cycle valid pulse, data held between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= 8'd0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= 8'd0;
    end else begin
      r_a_rvalid <= w_gnt_vec[0];
      r_b_rvalid <= w_gnt_vec[1];
      if (w_gnt_vec[0]) r_a_rdata <= r_tbl[a_idx];
      if (w_gnt_vec[1]) r_b_rdata <= r_tbl[b_idx];
    end
  end

  assign a_gnt    = w_gnt_vec[0];
  assign b_gnt    = w_gnt_vec[1];
  assign w_gnt    = w_gnt_vec[2];
  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rvalid = r_b_rvalid;
  assign b_rdata  = r_b_rdata;
  assign ready    = (r_state == ST_RUN);

endmodule

// File: tb/tb_imm_table_ctrl.sv
// tb_imm_table_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the immediate table controller.
module tb_imm_table_ctrl;

  logic       clk = 1'b0;
  logic       reset, reload;
  logic       a_req, b_req, w_req;
  logic [2:0] a_idx, b_idx, w_idx;
  logic [7:0] w_data;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, w_gnt, ready;
  logic [7:0] a_rdata, b_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_table_ctrl dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_idx(a_idx), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_idx(b_idx), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .w_req(w_req), .w_idx(w_idx), .w_data(w_data), .w_gnt(w_gnt),
    .reload(reload), .ready(ready)
  );

  // ---------------- reference model ----------------
  logic [7:0] def_tbl [8];
  logic [7:0] m_tbl [8];
  int         m_init_left;  // INIT cycles still to run; 0 means RUN
  int         m_ptr;        // 0=A, 1=B, 2=W
  logic       m_av, m_bv;
  logic [7:0] m_ad, m_bd;

  // Which requester wins this cycle (-1 when nobody may be granted).
  function automatic int model_pick();
    bit r [3];
    r[0] = a_req; r[1] = b_req; r[2] = w_req;
    if (reset || reload || m_init_left != 0) return -1;
    for (int k = 0; k < 3; k++) begin
      int j = (m_ptr + k) % 3;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_advance(input int g);
    if (reset) begin
      m_init_left = 8; m_ptr = 0;
      m_av = 1'b0; m_bv = 1'b0; m_ad = 8'd0; m_bd = 8'd0;
    end else begin
      m_av = (g == 0);
      m_bv = (g == 1);
      if (g == 0) m_ad = m_tbl[a_idx];
      if (g == 1) m_bd = m_tbl[b_idx];
      if (m_init_left != 0) begin
        if (reload) m_init_left = 8;
        else begin
          m_tbl[8 - m_init_left] = def_tbl[8 - m_init_left];
          m_init_left--;
        end
        m_ptr = 0;
      end else if (reload) begin
        m_init_left = 8; m_ptr = 0;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % 3;
        if (g == 2) m_tbl[w_idx] = w_data;
      end
    end
  endtask

  // ---------------- cycle driver ----------------
  logic [2:0] obs_gnt, exp_gnt;
  logic       obs_ready, obs_av, obs_bv;
  logic [7:0] obs_ad, obs_bd;

  // Drive one cycle of inputs (called at a falling edge); grants are sampled
  // mid-cycle, registered outputs 1 time unit after the rising edge.
  task automatic cyc(input bit rs, input bit rl,
                     input bit ra, input logic [2:0] ai,
                     input bit rb, input logic [2:0] bi,
                     input bit rw, input logic [2:0] wi, input logic [7:0] wd);
    int g;
    reset = rs; reload = rl;
    a_req = ra; a_idx = ai; b_req = rb; b_idx = bi;
    w_req = rw; w_idx = wi; w_data = wd;
    #1;
    obs_gnt = {w_gnt, b_gnt, a_gnt};
    g = model_pick();
    exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
    @(posedge clk);
    model_advance(g);
    #1;
    obs_ready = ready; obs_av = a_rvalid; obs_bv = b_rvalid;
    obs_ad = a_rdata; obs_bd = b_rdata;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 8'd0);
  endtask

  // Idle until ready, counting low samples including the current one (bounded).
  task automatic wait_ready(output int n_low);
    n_low = (obs_ready !== 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && obs_ready !== 1'b1; i++) begin
      idle();
      if (obs_ready !== 1'b1) n_low++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cyc(1, 0, 1, 3'd1, 1, 3'd2, 1, 3'd3, 8'h12);
    cyc(1, 1, 1, 3'd1, 1, 3'd2, 1, 3'd3, 8'h12);
    n_cmp++; if (obs_gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt got=%b exp=000", obs_gnt); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    n_cmp++; if ({obs_av, obs_bv} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=00", {obs_av, obs_bv}); end
    n_cmp++; if (obs_ad !== 8'd0) begin n_bad++; $display("FAIL reset_a_rdata got=%h exp=00", obs_ad); end
    n_cmp++; if (obs_bd !== 8'd0) begin n_bad++; $display("FAIL reset_b_rdata got=%h exp=00", obs_bd); end
  endtask

  task automatic test_init_defaults();
    int n_low;
    n_low = 1;
    // Requests during INIT must be ignored.
    for (int i = 0; i < 20 && obs_ready !== 1'b1; i++) begin
      cyc(0, 0, 1, 3'($urandom), 1, 3'($urandom), 1, 3'($urandom), 8'($urandom));
      n_cmp++; if (obs_gnt !== 3'b000) begin n_bad++; $display("FAIL init_gnt got=%b exp=000", obs_gnt); end
      if (obs_ready !== 1'b1) n_low++;
    end
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL init_timeout ready=%b exp=1", obs_ready); end
    n_cmp++; if (n_low !== 8) begin n_bad++; $display("FAIL init_len got=%0d exp=8", n_low); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 3'd0, 1, 3'(i), 0, 3'd0, 8'd0);
      n_cmp++; if (obs_gnt !== 3'b010) begin n_bad++; $display("FAIL dflt_gnt idx=%0d got=%b exp=010", i, obs_gnt); end
      n_cmp++; if (obs_bv !== 1'b1 || obs_bd !== def_tbl[i]) begin
        n_bad++; $display("FAIL dflt_read idx=%0d got=%b/%0d exp=1/%0d", i, obs_bv, obs_bd, def_tbl[i]);
      end
    end
    idle();
    n_cmp++; if (obs_bv !== 1'b0 || obs_bd !== def_tbl[7]) begin
      n_bad++; $display("FAIL rvalid_pulse got=%b/%0d exp=0/%0d", obs_bv, obs_bd, def_tbl[7]);
    end
  endtask

  task automatic test_round_robin();
    // A lone W grant moves the pointer back to A; writing the default keeps contents.
    cyc(0, 0, 0, 3'd0, 0, 3'd0, 1, 3'd7, 8'd0);
    n_cmp++; if (obs_gnt !== 3'b100) begin n_bad++; $display("FAIL rr_prep got=%b exp=100", obs_gnt); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 3'($urandom), 1, 3'($urandom), 1, 3'd6 + 3'(i % 2), 8'($urandom));
      n_cmp++; if (obs_gnt !== 3'(1 << (i % 3))) begin
        n_bad++; $display("FAIL rr_order step=%0d got=%b exp=%b", i, obs_gnt, 3'(1 << (i % 3)));
      end
      n_cmp++; if (obs_av !== (i % 3 == 0) || obs_bv !== (i % 3 == 1)) begin
        n_bad++; $display("FAIL rr_rvalid step=%0d got=%b%b", i, obs_av, obs_bv);
      end
      n_cmp++; if (obs_ad !== m_ad || obs_bd !== m_bd) begin
        n_bad++; $display("FAIL rr_rdata step=%0d got=%h/%h exp=%h/%h", i, obs_ad, obs_bd, m_ad, m_bd);
      end
    end
  endtask

  task automatic test_write_read();
    cyc(0, 0, 0, 3'd0, 0, 3'd0, 1, 3'd3, 8'h55);
    n_cmp++; if (obs_gnt !== 3'b100) begin n_bad++; $display("FAIL wr_gnt got=%b exp=100", obs_gnt); end
    cyc(0, 0, 1, 3'd3, 0, 3'd0, 0, 3'd0, 8'd0);
    n_cmp++; if (obs_gnt !== 3'b001) begin n_bad++; $display("FAIL rd_gnt got=%b exp=001", obs_gnt); end
    n_cmp++; if (obs_av !== 1'b1 || obs_ad !== 8'h55) begin
      n_bad++; $display("FAIL raw got=%b/%h exp=1/55", obs_av, obs_ad);
    end
  endtask

  task automatic test_reload();
    int n_low;
    cyc(0, 0, 0, 3'd0, 0, 3'd0, 1, 3'd2, 8'hAA);
    cyc(0, 1, 1, 3'd2, 1, 3'd2, 1, 3'd2, 8'h11);
    n_cmp++; if (obs_gnt !== 3'b000) begin n_bad++; $display("FAIL reload_gnt got=%b exp=000", obs_gnt); end
    wait_ready(n_low);
    n_cmp++; if (n_low !== 8 || obs_ready !== 1'b1) begin
      n_bad++; $display("FAIL reload_len got=%0d/%b exp=8/1", n_low, obs_ready);
    end
    cyc(0, 0, 0, 3'd0, 1, 3'd2, 0, 3'd0, 8'd0);
    n_cmp++; if (obs_bv !== 1'b1 || obs_bd !== 8'd29) begin
      n_bad++; $display("FAIL reload_restore got=%b/%0d exp=1/29", obs_bv, obs_bd);
    end
  endtask

  task automatic test_reload_pending();
    int n_low;
    logic [2:0] k;
    k = 3'($urandom_range(1, 5));
    cyc(0, 0, 1, k, 0, 3'd0, 0, 3'd0, 8'd0);
    n_cmp++; if (obs_gnt !== 3'b001) begin n_bad++; $display("FAIL pend_gnt got=%b exp=001", obs_gnt); end
    n_cmp++; if (obs_av !== 1'b1 || obs_ad !== def_tbl[k]) begin
      n_bad++; $display("FAIL pend_resp got=%b/%0d exp=1/%0d", obs_av, obs_ad, def_tbl[k]);
    end
    cyc(0, 1, 0, 3'd0, 1, 3'd1, 0, 3'd0, 8'd0);
    n_cmp++; if (obs_gnt !== 3'b000) begin n_bad++; $display("FAIL pend_reload_gnt got=%b exp=000", obs_gnt); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL pend_ready got=%b exp=0", obs_ready); end
    wait_ready(n_low);
  endtask

  task automatic test_reset_mid_init();
    int n_low;
    cyc(0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 8'd0);
    repeat (4) idle();
    cyc(1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 8'd0);
    wait_ready(n_low);
    n_cmp++; if (n_low !== 8 || obs_ready !== 1'b1) begin
      n_bad++; $display("FAIL midinit_len got=%0d/%b exp=8/1", n_low, obs_ready);
    end
    // Reset with a response in flight drops it and overrides a new request.
    cyc(0, 0, 1, 3'd4, 0, 3'd0, 0, 3'd0, 8'd0);
    cyc(1, 0, 1, 3'd4, 0, 3'd0, 0, 3'd0, 8'd0);
    n_cmp++; if (obs_gnt !== 3'b000) begin n_bad++; $display("FAIL rst_override_gnt got=%b exp=000", obs_gnt); end
    n_cmp++; if (obs_av !== 1'b0 || obs_ad !== 8'd0) begin
      n_bad++; $display("FAIL rst_drop got=%b/%h exp=0/00", obs_av, obs_ad);
    end
    wait_ready(n_low);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 40) == 0,
          1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
          1'($urandom), 3'($urandom), 8'($urandom));
      n_cmp++; if (obs_gnt !== exp_gnt) begin n_bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, obs_gnt, exp_gnt); end
      n_cmp++; if (obs_ready !== (m_init_left == 0)) begin
        n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, obs_ready, m_init_left == 0);
      end
      n_cmp++; if (obs_av !== m_av || obs_bv !== m_bv) begin
        n_bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", i, obs_av, obs_bv, m_av, m_bv);
      end
      n_cmp++; if (obs_ad !== m_ad || obs_bd !== m_bd) begin
        n_bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", i, obs_ad, obs_bd, m_ad, m_bd);
      end
    end
  endtask

  initial begin
    def_tbl = '{8'd0, 8'd1, 8'd29, 8'd128, 8'd59, 8'd4, 8'd0, 8'd0};
    m_init_left = 8; m_ptr = 0;
    m_av = 1'b0; m_bv = 1'b0; m_ad = 8'd0; m_bd = 8'd0;
    reset = 1'b1; reload = 1'b0;
    a_req = 1'b0; b_req = 1'b0; w_req = 1'b0;
    a_idx = 3'd0; b_idx = 3'd0; w_idx = 3'd0; w_data = 8'd0;
    obs_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_init_defaults();
    test_round_robin();
    test_write_read();
    test_reload();
    test_reload_pending();
    test_reset_mid_init();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_table_ctrl.md
IMM_TABLE_CTRL -- requirements
Module: imm_table_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: a_req  in  1 / a_idx  in  3 / a_gnt  out  1 / a_rvalid  out  1 / a_rdata  out  8  core-decode read requester.
REQ-004 SHALL have ports: b_req  in  1 / b_idx  in  3 / b_gnt  out  1 / b_rvalid  out  1 / b_rdata  out  8  debug read requester.
REQ-005 SHALL have ports: w_req  in  1 / w_idx  in  3 / w_data  in  8 / w_gnt  out  1  table-write requester.
REQ-006 SHALL have ports: reload  in  1  pulse that restores default table contents.
REQ-007 SHALL have ports: ready  out  1  high when the table is in RUN and may grant requests.

Function
REQ-008 SHALL hold an 8-entry x 8-bit immediate table in registers, exactly one access (read or write) per cycle.
REQ-009 SHALL use defaults idx0..7 = 0, 1, 29, 128, 59, 4, 0, 0.
REQ-010 SHALL implement FSM states INIT and RUN; reset enters INIT with init counter = 0.
REQ-011 INIT: each cycle writes default[counter] to entry[counter] and increments the counter; after writing idx 7 moves to RUN (8 INIT cycles total).
REQ-012 INIT: ready = 0, all gnt = 0; requests are ignored, not queued.
REQ-013 RUN: ready = 1; reload = 1 moves to INIT with counter = 0 on the next edge; no grant issued in the reload cycle.
REQ-014 reload asserted during INIT SHALL restart the counter at 0.
REQ-015 Grants SHALL be combinational from the current req inputs and arbiter pointer; at most one gnt high per cycle; gnt only when the matching req is high.
REQ-016 Arbitration SHALL be round-robin over order A(0), B(1), W(2), searching from the pointer; after a grant the pointer = granted index + 1 mod 3; with no grant the pointer holds.
REQ-017 Arbiter pointer SHALL reset to A and SHALL be reset to A on entry to INIT.
REQ-018 Granted read: idx is sampled in the grant cycle N; *_rvalid = 1 and *_rdata = entry[idx] in cycle N+1 only (1-cycle pulse, latency 1).
REQ-019 *_rdata SHALL hold its last value when *_rvalid = 0.
REQ-020 Granted write: entry[w_idx] = w_data at the end of grant cycle N; a read granted in N+1 or later SHALL return the new value.
REQ-021 A read response whose grant preceded a reload SHALL still be delivered in the following cycle, with the value sampled at grant.
REQ-022 Requesters hold req until gnt; a request not granted in a cycle has no side effect.

Reset
REQ-023 In the cycle after reset is sampled high: state = INIT, counter = 0, pointer = A, ready = 0, all gnt = 0, all rvalid = 0, all rdata = 0.
REQ-024 Reset SHALL override reload and all requests, including mid-INIT and with a read response pending (the pending response is dropped).
REQ-025 Table contents are defined only after INIT completes; reads are impossible before then.

Verification
REQ-026 Reset release, no requests -> ready = 0 for exactly 8 cycles, then 1; B reads idx 0..7 in turn -> 0,1,29,128,59,4,0,0, each rvalid one cycle after gnt.
REQ-027 A, B, W all requesting continuously from pointer A -> grants A, B, W, A, B, W; each rvalid one cycle after its gnt.
REQ-028 W writes idx 3 = 8'h55 in cycle N, A reads idx 3 granted in N+1 -> a_rdata = 8'h55 in N+2.
REQ-029 After write idx 2 = 8'hAA, reload pulse -> ready low for 8 cycles; subsequent read idx 2 returns 29.
REQ-030 A granted in cycle N, reload in cycle N+1 -> a_rvalid = 1 with the old value in N+1, no gnt in N+1, ready = 0 from N+2.
REQ-031 reset asserted mid-INIT (counter = 4) -> INIT restarts; ready rises exactly 8 cycles after reset is released.
